// File: rtl/fpu_operand_unpack_if.sv
// Handshake and decoded-field bundle for fpu_operand_unpack.
// Optional FCLASS fields exist only when FPU_UNPACK_FCLASS_EN is defined.
interface fpu_operand_unpack_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_A;
    logic [31:0] op_B;
    logic        out_valid;
    logic        out_ready;
    logic        sign_A;
    logic        sign_B;
    logic [7:0]  exp_A;
    logic [7:0]  exp_B;
    logic [23:0] sig_A;
    logic [23:0] sig_B;
    logic        isNaNA;
    logic        isNaNB;
    logic        isSignaling;
    logic        isZeroA;
    logic        isZeroB;
    logic        isInfA;
    logic        isInfB;
    logic        isSubA;
    logic        isSubB;
`ifdef FPU_UNPACK_FCLASS_EN
    logic [9:0]  fclass_A;
    logic [9:0]  fclass_B;

    modport master (
        output flush, in_valid, op_A, op_B, out_ready,
        input  in_ready, out_valid, sign_A, sign_B, exp_A, exp_B, sig_A, sig_B,
        input  isNaNA, isNaNB, isSignaling, isZeroA, isZeroB, isInfA, isInfB,
        input  isSubA, isSubB, fclass_A, fclass_B
    );
    modport slave (
        input  flush, in_valid, op_A, op_B, out_ready,
        output in_ready, out_valid, sign_A, sign_B, exp_A, exp_B, sig_A, sig_B,
        output isNaNA, isNaNB, isSignaling, isZeroA, isZeroB, isInfA, isInfB,
        output isSubA, isSubB, fclass_A, fclass_B
    );
`else
    modport master (
        output flush, in_valid, op_A, op_B, out_ready,
        input  in_ready, out_valid, sign_A, sign_B, exp_A, exp_B, sig_A, sig_B,
        input  isNaNA, isNaNB, isSignaling, isZeroA, isZeroB, isInfA, isInfB,
        input  isSubA, isSubB
    );
    modport slave (
        input  flush, in_valid, op_A, op_B, out_ready,
        output in_ready, out_valid, sign_A, sign_B, exp_A, exp_B, sig_A, sig_B,
        output isNaNA, isNaNB, isSignaling, isZeroA, isZeroB, isInfA, isInfB,
        output isSubA, isSubB
    );
`endif
endinterface

// File: rtl/fpu_operand_unpack.sv
// Binary32 operand-pair decoder with a 2-entry skid FIFO and registered in_ready.
// Define FPU_UNPACK_FCLASS_EN to add per-entry one-hot FCLASS.S outputs.
module fpu_operand_unpack (
    input  logic                 clk,
    input  logic                 reset,
    fpu_operand_unpack_if.slave  bus
);

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] sig;
        logic        nan;
        logic        snan;
        logic        inf;
        logic        zero;
        logic        sub;
`ifdef FPU_UNPACK_FCLASS_EN
        logic [9:0]  fclass;
`endif
    } dec_t;

    function automatic dec_t decode(input logic [31:0] op);
        dec_t d;
        logic exp_max;
        logic exp_min;
        logic frac_zero;
        logic normal;
        d         = '0;
        exp_max   = (op[30:23] == 8'hFF);
        exp_min   = (op[30:23] == 8'h00);
        frac_zero = (op[22:0] == 23'd0);
        normal    = ~exp_max & ~exp_min;
        d.sign    = op[31];
        d.exp     = op[30:23];
        d.sig     = {~exp_min, op[22:0]};
        d.nan     = exp_max & ~frac_zero;
        d.snan    = exp_max & ~frac_zero & ~op[22];
        d.inf     = exp_max & frac_zero;
        d.zero    = exp_min & frac_zero;
        d.sub     = exp_min & ~frac_zero;
`ifdef FPU_UNPACK_FCLASS_EN
        d.fclass[0] = op[31] & d.inf;
        d.fclass[1] = op[31] & normal;
        d.fclass[2] = op[31] & d.sub;
        d.fclass[3] = op[31] & d.zero;
        d.fclass[4] = ~op[31] & d.zero;
        d.fclass[5] = ~op[31] & d.sub;
        d.fclass[6] = ~op[31] & normal;
        d.fclass[7] = ~op[31] & d.inf;
        d.fclass[8] = d.snan;
        d.fclass[9] = d.nan & op[22];
`else
        d.sub     = d.sub | (normal & 1'b0);
`endif
        return d;
    endfunction

    dec_t       r_mem_a [2];
    dec_t       r_mem_b [2];
    logic [1:0] r_count;
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic       r_in_ready;

    logic       w_push;
    logic       w_pop;
    logic       w_out_valid;
    logic [1:0] w_count_next;
    dec_t       w_head_a;
    dec_t       w_head_b;

    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = bus.in_valid & r_in_ready & ~bus.flush;
    assign w_pop       = w_out_valid & bus.out_ready & ~bus.flush;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Flush takes priority over any handshake in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_in_ready <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_mem_a[i] <= '0;
                r_mem_b[i] <= '0;
            end
        end else if (bus.flush) begin
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem_a[r_wr_ptr] <= decode(bus.op_A);
                r_mem_b[r_wr_ptr] <= decode(bus.op_B);
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next < 2'd2);
        end
    end

    assign w_head_a = r_mem_a[r_rd_ptr];
    assign w_head_b = r_mem_b[r_rd_ptr];

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.sign_A      = w_head_a.sign;
    assign bus.sign_B      = w_head_b.sign;
    assign bus.exp_A       = w_head_a.exp;
    assign bus.exp_B       = w_head_b.exp;
    assign bus.sig_A       = w_head_a.sig;
    assign bus.sig_B       = w_head_b.sig;
    assign bus.isNaNA      = w_head_a.nan;
    assign bus.isNaNB      = w_head_b.nan;
    assign bus.isSignaling = w_head_a.snan | w_head_b.snan;
    assign bus.isZeroA     = w_head_a.zero;
    assign bus.isZeroB     = w_head_b.zero;
    assign bus.isInfA      = w_head_a.inf;
    assign bus.isInfB      = w_head_b.inf;
    assign bus.isSubA      = w_head_a.sub;
    assign bus.isSubB      = w_head_b.sub;
`ifdef FPU_UNPACK_FCLASS_EN
    assign bus.fclass_A    = w_head_a.fclass;
    assign bus.fclass_B    = w_head_b.fclass;
`endif

endmodule

// File: tb/tb_fpu_operand_unpack.sv
// Scoreboard bench for fpu_operand_unpack: directed vectors with hand-decoded expectations.
// Build with FPU_UNPACK_FCLASS_EN defined to also check the FCLASS outputs.
module tb_fpu_operand_unpack;

    typedef struct {
        logic        sA;
        logic [7:0]  eA;
        logic [23:0] gA;
        logic [3:0]  fA;
        logic [9:0]  cA;
        logic        sB;
        logic [7:0]  eB;
        logic [23:0] gB;
        logic [3:0]  fB;
        logic [9:0]  cB;
        logic        snan;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [31:0] va [7];
    logic [31:0] vb [7];
    exp_t        ev [7];
    exp_t        sb [$];

    fpu_operand_unpack_if bus ();

    fpu_operand_unpack u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: a pop happens on the next rising edge whenever valid & ready hold here.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sign_A", {31'd0, bus.sign_A}, {31'd0, e.sA});
                chk("exp_A",  {24'd0, bus.exp_A},  {24'd0, e.eA});
                chk("sig_A",  {8'd0, bus.sig_A},   {8'd0, e.gA});
                chk("flags_A(nan,inf,zero,sub)",
                    {28'd0, bus.isNaNA, bus.isInfA, bus.isZeroA, bus.isSubA}, {28'd0, e.fA});
                chk("sign_B", {31'd0, bus.sign_B}, {31'd0, e.sB});
                chk("exp_B",  {24'd0, bus.exp_B},  {24'd0, e.eB});
                chk("sig_B",  {8'd0, bus.sig_B},   {8'd0, e.gB});
                chk("flags_B(nan,inf,zero,sub)",
                    {28'd0, bus.isNaNB, bus.isInfB, bus.isZeroB, bus.isSubB}, {28'd0, e.fB});
                chk("isSignaling", {31'd0, bus.isSignaling}, {31'd0, e.snan});
`ifdef FPU_UNPACK_FCLASS_EN
                chk("fclass_A", {22'd0, bus.fclass_A}, {22'd0, e.cA});
                chk("fclass_B", {22'd0, bus.fclass_B}, {22'd0, e.cB});
`endif
            end
        end
    end

    task automatic send(input int idx);
        bit done;
        done = 0;
        bus.op_A     = va[idx];
        bus.op_B     = vb[idx];
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(ev[idx]);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        chk("drain_remaining", sb.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        n_checks = 0;
        n_fail   = 0;

        va[0] = 32'h3F800000; vb[0] = 32'h00000000;
        va[1] = 32'h7F800001; vb[1] = 32'h7FC00000;
        va[2] = 32'h00000001; vb[2] = 32'hFF800000;
        va[3] = 32'hC0490FDB; vb[3] = 32'h80000000;
        va[4] = 32'h807FFFFF; vb[4] = 32'h7F800000;
        va[5] = 32'hFFBFFFFF; vb[5] = 32'h3F800000;
        va[6] = 32'h12345678; vb[6] = 32'h9ABCDEF0;
        // sign, exp, sig, {nan,inf,zero,sub}, fclass  (A then B), isSignaling
        ev[0] = '{1'b0, 8'h7F, 24'h800000, 4'b0000, 10'h040,
                  1'b0, 8'h00, 24'h000000, 4'b0010, 10'h010, 1'b0};
        ev[1] = '{1'b0, 8'hFF, 24'h800001, 4'b1000, 10'h100,
                  1'b0, 8'hFF, 24'hC00000, 4'b1000, 10'h200, 1'b1};
        ev[2] = '{1'b0, 8'h00, 24'h000001, 4'b0001, 10'h020,
                  1'b1, 8'hFF, 24'h800000, 4'b0100, 10'h001, 1'b0};
        ev[3] = '{1'b1, 8'h80, 24'hC90FDB, 4'b0000, 10'h002,
                  1'b1, 8'h00, 24'h000000, 4'b0010, 10'h008, 1'b0};
        ev[4] = '{1'b1, 8'h00, 24'h7FFFFF, 4'b0001, 10'h004,
                  1'b0, 8'hFF, 24'h800000, 4'b0100, 10'h080, 1'b0};
        ev[5] = '{1'b1, 8'hFF, 24'hBFFFFF, 4'b1000, 10'h100,
                  1'b0, 8'h7F, 24'h800000, 4'b0000, 10'h040, 1'b1};
        ev[6] = '{1'b0, 8'h24, 24'hB45678, 4'b0000, 10'h040,
                  1'b1, 8'h35, 24'hBCDEF0, 4'b0000, 10'h002, 1'b0};

        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_A      = '0;
        bus.op_B      = '0;

        repeat (2) @(posedge clk);
        #2;
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_sig_A_not_x", {8'd0, bus.sig_A}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

        // Basic decode and single-cycle latency
        bus.out_ready = 1'b1;
        send(0);
        chk("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
        send(1);
        send(2);
        drain();

        // Back-pressure: three offered back-to-back, only two fit
        bus.out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 3; k++) begin
            bus.op_A     = va[3 + k];
            bus.op_B     = vb[3 + k];
            bus.in_valid = 1'b1;
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(ev[3 + k]);
                acc++;
            end
            @(posedge clk);
            #1;
            if (k == 1) chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        chk("accepted_when_full", acc, 32'd2);
        chk("full_out_valid_held", {31'd0, bus.out_valid}, 32'd1);
        chk("held_sig_A_stable", {8'd0, bus.sig_A}, {8'd0, ev[3].gA});
        bus.out_ready = 1'b1;
        drain();

        // Flush with FIFO full and a pair offered in the same cycle
        bus.out_ready = 1'b0;
        send(0);
        send(1);
        bus.op_A     = va[6];
        bus.op_B     = vb[6];
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        sb.delete();
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_flush_idle", {31'd0, bus.out_valid}, 32'd0);
        send(5);
        send(2);
        drain();

        // Asynchronous reset between edges with entries buffered
        bus.out_ready = 1'b0;
        send(3);
        send(4);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        sb.delete();
        @(posedge clk);
        #4;
        reset = 1'b0;
        #1;
        chk("in_ready_before_edge", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready_after_release", {31'd0, bus.in_ready}, 32'd1);
        chk("out_valid_after_release", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        send(3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_operand_unpack.md
FPU_OPERAND_UNPACK -- requirements
Module: fpu_operand_unpack

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-002 The module SHALL have the port reset, input, 1 bit, an asynchronous active-high reset.
REQ-003 The module SHALL have the port flush, input, 1 bit, a synchronous discard of all buffered operand pairs.
REQ-004 The module SHALL have the port in_valid, input, 1 bit, an operand pair offered.
REQ-005 The module SHALL have the port in_ready, output, 1 bit, signalling that the block accepts a pair this cycle.
REQ-006 The module SHALL have the ports op_A and op_B, inputs, 32 bits each, raw IEEE-754 binary32 words.
REQ-007 The module SHALL have the port out_valid, output, 1 bit, an unpacked pair presented.
REQ-008 The module SHALL have the port out_ready, input, 1 bit, signalling that the downstream consumer (min/max, compare) accepts.
REQ-009 The module SHALL have the ports sign_A and sign_B, outputs, 1 bit each, the operand signs.
REQ-010 The module SHALL have the ports exp_A and exp_B, outputs, 8 bits each, the biased exponents.
REQ-011 The module SHALL have the ports sig_A and sig_B, outputs, 24 bits each, the significands with the hidden bit at bit 23.
REQ-012 The module SHALL have the ports isNaNA and isNaNB, outputs, 1 bit each, flagging an operand as NaN.
REQ-013 The module SHALL have the port isSignaling, output, 1 bit, set when either operand is a signalling NaN.
REQ-014 The module SHALL have the ports isZeroA, isZeroB, isInfA, isInfB, isSubA and isSubB, outputs, 1 bit each, the operand class flags.

Function
REQ-015 A transfer SHALL occur on the input side when in_valid & in_ready are both high, and on the output side when out_valid & out_ready are both high.
REQ-016 Accepted pairs SHALL be decoded and stored in a 2-entry FIFO, and results SHALL be presented in acceptance order.
REQ-017 Latency SHALL be 1 cycle: a pair accepted at edge N SHALL appear with out_valid=1 after edge N when the FIFO was empty.
REQ-018 in_ready SHALL be a registered signal equal to (count<2); there SHALL be no combinational path from out_ready to in_ready.
REQ-019 When count=2 and a push and a pop occur in the same cycle, that case SHALL be unreachable because in_ready=0.
REQ-020 When 0<count<2 and a push and a pop occur in the same cycle, count SHALL remain unchanged and order SHALL be preserved.
REQ-021 Read and write pointers SHALL be 1 bit each and SHALL wrap modulo 2.
REQ-022 Output fields SHALL be driven from the head entry; while out_valid=1 and out_ready=0 they SHALL remain stable.
REQ-023 sign SHALL equal op[31], and exp SHALL equal op[30:23].
REQ-024 sig SHALL equal {exp!=0, op[22:0]}.
REQ-025 isNaN SHALL be set when exp=FF and frac!=0.
REQ-026 isInf SHALL be set when exp=FF and frac=0.
REQ-027 isZero SHALL be set when exp=0 and frac=0.
REQ-028 isSub SHALL be set when exp=0 and frac!=0.
REQ-029 isSignaling SHALL equal (isNaNA & ~op_A[22]) | (isNaNB & ~op_B[22]).
REQ-030 flush SHALL set count to 0, reset both pointers, set in_ready=1 and set out_valid=0 on the next edge; a pair offered in the flush cycle SHALL be dropped.
REQ-031 When out_valid=0, the output field values SHALL be don't-care but SHALL NOT be X after reset.

Reset
REQ-032 While reset is high, count, pointers and out_valid SHALL be 0, in_ready SHALL be 0, and all storage SHALL be cleared to 0.
REQ-033 in_ready SHALL rise on the first clk edge after reset deasserts.
REQ-034 Reset asserted mid-transfer SHALL discard all entries immediately, without waiting for a clock.

Configuration
REQ-035 When FPU_UNPACK_FCLASS_EN is defined, the module SHALL add the outputs fclass_A and fclass_B, 10 bits each, one-hot RISC-V FCLASS.S encodings: bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0, bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf, bit8 sNaN, bit9 qNaN; these SHALL be stored per entry and follow the same handshake.
REQ-036 When FPU_UNPACK_FCLASS_EN is undefined, the fclass ports and their storage SHALL be absent, with all other behaviour identical.

Verification
REQ-037 The bench SHALL drive op_A=3F800000 and op_B=00000000 into an empty FIFO with out_ready=1 and SHALL require, one cycle later, out_valid=1, sig_A=800000, exp_A=7F, isZeroB=1 and isSignaling=0.
REQ-038 The bench SHALL drive op_A=7F800001 and op_B=7FC00000 and SHALL require isNaNA=1, isNaNB=1 and isSignaling=1; with FCLASS enabled, fclass_A=100 (hex) and fclass_B=200 (hex).
REQ-039 The bench SHALL drive op_A=00000001 and op_B=FF800000 and SHALL require isSubA=1, sig_A=000001, isInfB=1 and sign_B=1.
REQ-040 The bench SHALL hold out_ready=0, push 3 pairs back-to-back and SHALL require only 2 accepted, in_ready=0 after the second edge, and in-order pops once out_ready=1.
REQ-041 The bench SHALL assert flush with count=2 and in_valid=1 and SHALL require, next cycle, out_valid=0, in_ready=1 and the offered pair never appearing.
REQ-042 The bench SHALL assert reset asynchronously mid-stream between edges and SHALL require out_valid=0 and in_ready=0 immediately, with in_ready=1 one edge after release.
